// File: rtl/mpu_sample_scheduler.sv
// mpu_sample_scheduler: MPU6050 init sequence plus periodic accel/gyro burst reads over a single-register I2C engine.
// Optional MPU_TEMP_READ_EN adds the temp output and widens the read list to the contiguous 0x3B..0x48.
module mpu_sample_scheduler #(
    parameter int SAMPLE_DIV = 500000,
    parameter int RESET_WAIT = 5000000,
    parameter int RETRY_MAX  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_rw,
    output logic [7:0]  cmd_reg,
    output logic [7:0]  cmd_wdata,
    input  logic        rsp_valid,
    input  logic        rsp_nack,
    input  logic [7:0]  rsp_rdata,
    output logic [15:0] acc_x,
    output logic [15:0] acc_y,
    output logic [15:0] acc_z,
    output logic [15:0] gyro_x,
    output logic [15:0] gyro_y,
    output logic [15:0] gyro_z,
`ifdef MPU_TEMP_READ_EN
    output logic [15:0] temp,
`endif
    output logic        sample_valid,
    output logic        init_done,
    output logic        overrun,
    output logic        err
);
`ifdef MPU_TEMP_READ_EN
    localparam int NRD = 14;
    localparam int GB  = 8;
`else
    localparam int NRD = 12;
    localparam int GB  = 6;
`endif
    localparam int TW = $clog2(SAMPLE_DIV);
    localparam int SW = $clog2(RESET_WAIT);
    localparam int RW = $clog2(RETRY_MAX + 1);
    // {reg, data} per init step, step 0 in the low 16 bits
    localparam logic [95:0] INIT_TAB = {16'h1C01, 16'h1B18, 16'h1A06, 16'h1907, 16'h6B00, 16'h6B80};

    typedef enum logic [2:0] {INIT_ISSUE, INIT_RSP, SETTLE, IDLE, RD_ISSUE, RD_RSP, PUBLISH} state_t;

    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic [SW-1:0] settle_cnt;
    logic [RW-1:0] retry;
    logic [3:0]    idx;
    logic [7:0]    shadow [NRD];
    logic          tick;
    logic          rd_phase;
    logic [7:0]    init_reg;
    logic [7:0]    init_wdata;
    logic [7:0]    rd_reg;

    assign tick = tick_cnt == TW'(SAMPLE_DIV - 1);
    assign rd_phase = state == RD_ISSUE || state == RD_RSP;
    assign {init_reg, init_wdata} = INIT_TAB[{idx, 4'b0000} +: 16];
`ifdef MPU_TEMP_READ_EN
    assign rd_reg = 8'h3B + {4'd0, idx};
`else
    assign rd_reg = idx < 4'd6 ? 8'h3B + {4'd0, idx} : 8'h3D + {4'd0, idx};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= INIT_ISSUE;
            tick_cnt     <= '0;
            settle_cnt   <= '0;
            retry        <= '0;
            idx          <= '0;
            shadow       <= '{default: '0};
            cmd_valid    <= 1'b0;
            cmd_rw       <= 1'b0;
            cmd_reg      <= '0;
            cmd_wdata    <= '0;
            acc_x        <= '0;
            acc_y        <= '0;
            acc_z        <= '0;
            gyro_x       <= '0;
            gyro_y       <= '0;
            gyro_z       <= '0;
`ifdef MPU_TEMP_READ_EN
            temp         <= '0;
`endif
            sample_valid <= 1'b0;
            init_done    <= 1'b0;
            overrun      <= 1'b0;
            err          <= 1'b0;
        end else begin
            tick_cnt     <= tick ? '0 : tick_cnt + 1'b1;
            sample_valid <= 1'b0;
            if (tick && (rd_phase || state == PUBLISH))
                overrun <= 1'b1;
            case (state)
                INIT_ISSUE, RD_ISSUE: begin
                    // every ISSUE entry arrives with cmd_valid low; the command is loaded one cycle later
                    if (!cmd_valid) begin
                        cmd_valid <= 1'b1;
                        cmd_rw    <= rd_phase;
                        cmd_reg   <= rd_phase ? rd_reg : init_reg;
                        cmd_wdata <= rd_phase ? 8'h00 : init_wdata;
                    end else if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= rd_phase ? RD_RSP : INIT_RSP;
                    end
                end
                INIT_RSP, RD_RSP: begin
                    if (rsp_valid) begin
                        if (rsp_nack) begin
                            if (retry == RW'(RETRY_MAX)) begin
                                err       <= 1'b1;
                                init_done <= 1'b0;
                                retry     <= '0;
                                idx       <= '0;
                                shadow    <= '{default: '0};
                                state     <= INIT_ISSUE;
                            end else begin
                                retry <= retry + 1'b1;
                                state <= rd_phase ? RD_ISSUE : INIT_ISSUE;
                            end
                        end else begin
                            retry <= '0;
                            idx   <= idx + 1'b1;
                            if (rd_phase) begin
                                shadow[idx] <= rsp_rdata;
                                state       <= idx == 4'(NRD - 1) ? PUBLISH : RD_ISSUE;
                            end else begin
                                settle_cnt <= '0;
                                state      <= idx == 4'd0 ? SETTLE : idx == 4'd5 ? IDLE : INIT_ISSUE;
                                if (idx == 4'd5)
                                    init_done <= 1'b1;
                            end
                        end
                    end
                end
                SETTLE: begin
                    // RESET_WAIT-1 cycles here plus the ISSUE load cycle give RESET_WAIT command-free cycles
                    settle_cnt <= settle_cnt + 1'b1;
                    if (settle_cnt == SW'(RESET_WAIT - 2))
                        state <= INIT_ISSUE;
                end
                IDLE: begin
                    if (tick) begin
                        idx   <= '0;
                        state <= RD_ISSUE;
                    end
                end
                PUBLISH: begin
                    acc_x        <= {shadow[0], shadow[1]};
                    acc_y        <= {shadow[2], shadow[3]};
                    acc_z        <= {shadow[4], shadow[5]};
                    gyro_x       <= {shadow[GB], shadow[GB+1]};
                    gyro_y       <= {shadow[GB+2], shadow[GB+3]};
                    gyro_z       <= {shadow[GB+4], shadow[GB+5]};
`ifdef MPU_TEMP_READ_EN
                    temp         <= {shadow[6], shadow[7]};
`endif
                    sample_valid <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= INIT_ISSUE;
            endcase
        end
    end
endmodule
